// File: rtl/life_wb_packer.sv
// Writeback packer: collects NUM_PE-bit next-state groups into WORD_SIZE-bit
// words and writes them to one of two BRAM banks with backpressure and a done pulse.
module life_wb_packer #(
  parameter int WORD_SIZE    = 16,
  parameter int NUM_PE       = 2,
  parameter int BOARD_SIZE   = 128,
  parameter int MAX_ADDR     = BOARD_SIZE * BOARD_SIZE / WORD_SIZE,
  parameter int LOG_MAX_ADDR = $clog2(MAX_ADDR)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    bank_sel_in,
  input  logic                    valid_in,
  input  logic [NUM_PE-1:0]       data_in,
  output logic                    ready_out,
  input  logic                    mem_busy_in,
  output logic                    wr_en_out,
  output logic [LOG_MAX_ADDR:0]   addr_w_out,
  output logic [WORD_SIZE-1:0]    data_w_out,
  output logic                    done_out
);

  localparam int GROUPS = WORD_SIZE / NUM_PE;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [WORD_SIZE-1:0]    pack;
  logic [WORD_SIZE-1:0]    pack_next;
  logic [GW-1:0]           grp_cnt;
  logic [LOG_MAX_ADDR-1:0] word_idx;
  logic [LOG_MAX_ADDR-1:0] idx_after_take;
  logic                    bank;
  logic                    accept;
  logic                    word_done;
  logic                    taken;
  logic                    last_take;

  // Handshake and write-completion decode
  always_comb begin
    ready_out      = (state == FILL) && !(wr_en_out && mem_busy_in);
    accept         = valid_in && ready_out;
    word_done      = accept && (grp_cnt == GW'(GROUPS - 1));
    taken          = wr_en_out && !mem_busy_in;
    last_take      = taken && (word_idx == LOG_MAX_ADDR'(MAX_ADDR - 1));
    // The cast keeps this legal when a single group fills the whole word.
    pack_next      = (pack << NUM_PE) | WORD_SIZE'(data_in);
    if (taken) begin
      idx_after_take = word_idx + LOG_MAX_ADDR'(1);
    end else begin
      idx_after_take = word_idx;
    end
  end

  // Next-state logic; start_in overrides every other event
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_in) begin
          state_next = FILL;
        end else begin
          state_next = IDLE;
        end
      end
      FILL: begin
        if (start_in) begin
          state_next = FILL;
        end else if (last_take) begin
          state_next = DONE;
        end else begin
          state_next = FILL;
        end
      end
      DONE: begin
        if (start_in) begin
          state_next = FILL;
        end else begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Packing datapath and write-port registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pack       <= '0;
      grp_cnt    <= '0;
      word_idx   <= '0;
      bank       <= 1'b0;
      wr_en_out  <= 1'b0;
      addr_w_out <= '0;
      data_w_out <= '0;
      done_out   <= 1'b0;
    end else if (start_in) begin
      pack      <= '0;
      grp_cnt   <= '0;
      word_idx  <= '0;
      bank      <= bank_sel_in;
      wr_en_out <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      done_out <= last_take;
      if (accept) begin
        pack <= pack_next;
        if (word_done) begin
          grp_cnt <= '0;
        end else begin
          grp_cnt <= grp_cnt + GW'(1);
        end
      end
      // word_idx stops at the last word instead of wrapping.
      if (taken && !last_take) begin
        word_idx <= word_idx + LOG_MAX_ADDR'(1);
      end
      if (last_take) begin
        wr_en_out <= 1'b0;
      end else if (word_done) begin
        wr_en_out  <= 1'b1;
        data_w_out <= pack_next;
        addr_w_out <= {bank, idx_after_take};
      end else if (taken) begin
        wr_en_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_life_wb_packer.sv
// Bench for life_wb_packer (W=8, P=2, 8x8 board): directed scenarios plus a
// randomized run, all checked against a queue-based word model.
module tb_life_wb_packer;

  localparam int W     = 8;
  localparam int P     = 2;
  localparam int BS    = 8;
  localparam int MAXA  = BS * BS / W;
  localparam int LOGA  = $clog2(MAXA);
  localparam int GRPS  = W / P;

  logic            clk;
  logic            rst;
  logic            start;
  logic            bank_sel;
  logic            valid;
  logic [P-1:0]    data;
  logic            ready;
  logic            busy;
  logic            wr_en;
  logic [LOGA:0]   addr_w;
  logic [W-1:0]    data_w;
  logic            done;

  life_wb_packer #(.WORD_SIZE(W), .NUM_PE(P), .BOARD_SIZE(BS)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .bank_sel_in(bank_sel),
    .valid_in(valid), .data_in(data), .ready_out(ready), .mem_busy_in(busy),
    .wr_en_out(wr_en), .addr_w_out(addr_w), .data_w_out(data_w), .done_out(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: groups of the current word in a queue, words counted per pass.
  int m_state;   // 0 idle, 1 filling, 2 finished
  int grp_q[$];
  int m_words;
  int m_bank;
  bit m_wr;
  bit m_done;
  int m_addr;
  int m_data;
  int n_done;

  task automatic model_reset();
    m_state = 0; grp_q.delete(); m_words = 0; m_bank = 0;
    m_wr = 1'b0; m_done = 1'b0; m_addr = 0; m_data = 0;
  endtask

  task automatic cycle(input logic s, input logic b, input logic v,
                       input logic [P-1:0] d, input logic bz);
    bit exp_ready;
    bit tk;
    bit new_wr;
    int word;
    @(negedge clk);
    start = s; bank_sel = b; valid = v; data = d; busy = bz;
    #1;
    exp_ready = (m_state == 1) && !(m_wr && bz);
    check("ready", 32'(ready), 32'(exp_ready));
    @(posedge clk);
    if (s) begin
      grp_q.delete(); m_words = 0; m_bank = int'(b);
      m_wr = 1'b0; m_done = 1'b0; m_state = 1;
    end else begin
      m_done = 1'b0;
      tk     = m_wr && !bz;
      new_wr = m_wr && !tk;
      if (tk) begin
        m_words++;
        if (m_words == MAXA) begin
          m_done = 1'b1;
          m_state = 2;
        end
      end
      if (v && exp_ready) begin
        grp_q.push_back(int'(d));
        if (grp_q.size() == GRPS) begin
          word = 0;
          foreach (grp_q[i]) word = (word << P) | grp_q[i];
          m_data = word;
          m_addr = m_bank * MAXA + m_words;
          new_wr = 1'b1;
          grp_q.delete();
        end
      end
      if (m_state == 2) new_wr = 1'b0;
      m_wr = new_wr;
    end
    #1;
    check("wr_en", 32'(wr_en), 32'(m_wr));
    check("done", 32'(done), 32'(m_done));
    if (done) n_done++;
    if (m_wr) begin
      check("addr", 32'(addr_w), 32'(m_addr));
      check("data", 32'(data_w), 32'(m_data));
    end
  endtask

  initial begin
    logic [LOGA:0]  held_addr;
    logic [W-1:0]   held_data;
    int             done_before;
    rst = 1'b1; start = 1'b0; bank_sel = 1'b0; valid = 1'b0; data = '0; busy = 1'b0;
    model_reset();
    n_done = 0;
    #3;
    check("rst_wr", 32'(wr_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_addr", 32'(addr_w), 32'd0);
    check("rst_data", 32'(data_w), 32'd0);
    #9 rst = 1'b0;

    // idle: valid without start is ignored
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);

    // 1: basic word
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 2'b00, 1'b0);
    check("t1_wr", 32'(wr_en), 32'd1);
    check("t1_data", 32'(data_w), 32'h9C);
    check("t1_addr", 32'(addr_w), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    check("t1_pulse", 32'(wr_en), 32'd0);

    // 2: bank 1
    cycle(1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
    repeat (GRPS) cycle(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    check("t2_addr", 32'(addr_w), 32'(MAXA));
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

    // 3: memory backpressure
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (GRPS) cycle(1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    held_addr = addr_w; held_data = data_w;
    repeat (3) begin
      cycle(1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
      check("t3_addr_hold", 32'(addr_w), 32'(held_addr));
      check("t3_data_hold", 32'(data_w), 32'h AA);
    end
    cycle(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    check("t3_after_take", 32'(wr_en), 32'd0);
    check("t3_queued", 32'(grp_q.size()), 32'd1);

    // 4: restart mid-word discards the partial word
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (GRPS) cycle(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    check("t4_data", 32'(data_w), 32'h55);
    check("t4_addr", 32'(addr_w), 32'd0);

    // 5: full pass back-to-back
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    done_before = n_done;
    for (int i = 0; i < MAXA * GRPS; i++) cycle(1'b0, 1'b0, 1'b1, P'(i), 1'b0);
    check("t5_last_addr", 32'(addr_w), 32'(MAXA - 1));
    cycle(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    check("t5_done", 32'(done), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 2'b11, 1'b0);
    check("t5_done_once", 32'(done), 32'd0);
    check("t5_ready_low", 32'(ready), 32'd0);
    check("t5_pulses", 32'(n_done - done_before), 32'd1);

    // 6: async reset in the middle of a pending write
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (GRPS) cycle(1'b0, 1'b0, 1'b1, 2'b10, 1'b0);
    @(negedge clk);
    busy = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t6_wr", 32'(wr_en), 32'd0);
    check("t6_ready", 32'(ready), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);

    // randomized traffic against the model
    cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 149) == 0), 1'($urandom), ($urandom_range(0, 9) < 7),
            P'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
